rr_onehot_arbiter: RTL and testbench
====================================

// Module: rr_onehot_arbiter
// PURPOSE
//  Round-robin arbiter for up to 16 requesters; produces a registered one-hot grant vector.
//  Sits directly upstream of the one-hot-to-binary encoder, which turns grant into a 4-bit index.
//  Grant is held until the owner signals done or drops its request; the priority pointer then rotates.
// PARAMETERS
//  N      16  number of requesters; legal range 2..16
//  PTR_W  4   pointer width; must equal $clog2(N)
// PORTS
//  clk      in   1      single clock, all state on posedge
//  rst      in   1      asynchronous, active-high reset
//  req      in   N      per-requester request level
//  done     in   1      pulse: current owner finished; ignored when no grant is held
//  grant    out  N      registered one-hot grant; all-zero when idle
//  busy     out  1      registered; high while any grant is held (== |grant)
//  lock     in   1      present only with ARB_LOCK_EN
// BEHAVIOUR
//  Reset (async assert, sync deassert use): grant=0, busy=0, ptr=0, state=IDLE.
//  State machine, 2 states:
//   - IDLE: if |req, latch winner=pick(req,ptr) into grant and go to GRANT; else stay.
//   - GRANT: hold grant. Release when done==1 OR req[owner]==0.
//     On release: grant=0, ptr=(owner+1) mod N, go to IDLE.
//  Pick rule: first set bit of req scanning upward from index ptr, wrapping N-1 -> 0.
//  Pointer arithmetic: owner+1 wraps to 0 when owner==N-1; there is no out-of-range pointer.
//  Latency:
//   - req rising in IDLE -> grant at the next posedge (1 cycle).
//   - release -> one mandatory IDLE cycle with grant=0 before the next grant (no back-to-back).
//  Invariants:
//   - grant is always either all-zero or exactly one-hot, so the downstream encoder never sees multi-hot.
//   - grant only ever asserts a bit whose req was high at the sampling edge.
//  done while in IDLE: ignored; no pointer change.
//  Owner re-requests in the release cycle: it is lowest priority for the next pick.
//  req changes from non-owners during GRANT have no effect until IDLE.
//  Reset asserted mid-grant: grant and busy clear immediately (async); the pointer returns to 0.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//   - adds input lock.
//   - While in GRANT with lock==1, done and a dropped req are both ignored, so the grant holds.
//   - Release happens on the first cycle with lock==0 and a release condition.
//  ARB_LOCK_EN undefined: no lock port; release exactly as above.
// STRUCTURE
//  Package arb_pkg holds:
//   - state enum {ARB_IDLE, ARB_GRANT}
//   - default N=16 and PTR_W=4 constants
//  Sub-module rr_pick (combinational): inputs req[N], ptr[PTR_W]; outputs one-hot win[N] and any.
//   - Implementation: double-width masked priority scan.
//  The top level holds the FSM, grant register, pointer register and owner index register.
// TESTING
//  T1 reset: rst=1 with req=16'hFFFF -> grant=0, busy=0; after rst=0, next edge grant=16'h0001.
//  T2 rotation: req=16'hFFFF held, done pulsed each GRANT cycle.
//     -> grants 0x0001, 0x0002, ... 0x8000, then 0x0001 (wrap); an idle cycle between each.
//  T3 fairness: req=16'h8001, ptr=0 -> grant 0x0001.
//     After done -> grant 0x8000; after done -> grant 0x0001.
//  T4 abandon: grant=0x0010, then req[4] drops with done=0.
//     -> next edge grant=0, ptr=5; with req=0x0011 the next grant is 0x0001.
//  T5 async reset mid-grant: assert rst between edges while grant=0x0100.
//     -> grant=0 immediately; after release, req=0x0100 -> grant 0x0100 with ptr 0.
//  T6 (ARB_LOCK_EN): grant=0x0004, lock=1, done=1 for 3 cycles -> grant stays 0x0004.
//     lock=0 with done=1 -> grant=0 next edge.
//  All tests: assert $onehot0(grant) every cycle; feed grant to the encoder and check index==owner.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin one-hot arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_N     = 16;
    localparam int ARB_PTR_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping N-1 -> 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int PTR_W = ARB_PTR_W
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             any
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] lowest;

    // Lower half keeps only bits >= ptr; the upper half is the full vector and
    // supplies the wrapped winner when nothing at or above ptr is requesting.
    always_comb begin
        hi_mask = ~((N'(1) << ptr) - N'(1));
        dbl     = {req, req & hi_mask};
        lowest  = dbl & (~dbl + (2*N)'(1));
        win     = lowest[N-1:0] | lowest[2*N-1:N];
        any     = |req;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until done or request drop.
// Optional feature: define ARB_LOCK_EN to add a lock input that holds the grant.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int PTR_W = ARB_PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
`ifdef ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic [N-1:0] grant,
    output logic         busy
);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;

    logic [N-1:0]     win;
    logic             req_any;
    logic             lock_hold;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .any (req_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    grant_d = win;
                    owner_d = onehot_to_idx(win);
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Releasing owner moves to lowest priority for the next pick.
                if (!lock_hold && (done || !req[owner_q])) begin
                    grant_d = '0;
                    ptr_d   = (owner_q == PTR_W'(N-1)) ? '0 : owner_q + 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d == ARB_GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed self-checking bench for rr_onehot_arbiter (lock scenario when ARB_LOCK_EN is defined).
module tb_rr_onehot_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        lock;
    logic [15:0] grant;
    logic        busy;

    int errors = 0;
    int checks = 0;

    rr_onehot_arbiter #(.N(16), .PTR_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .done  (done),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream one-hot-to-binary encoder model; -1 for all-zero or multi-hot.
    function automatic int enc(input logic [15:0] g);
        int idx;
        int cnt;
        idx = -1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (g[i]) begin
                idx = i;
                cnt++;
            end
        end
        if (cnt != 1) idx = -1;
        return idx;
    endfunction

    // Every-cycle invariants: one-hot-or-zero grant, busy mirrors grant.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(grant)) begin
            errors++;
            $display("FAIL onehot0 t=%0t grant=%h", $time, grant);
        end
        checks++;
        if (busy !== (|grant)) begin
            errors++;
            $display("FAIL busy_vs_grant t=%0t busy=%b grant=%h", $time, busy, grant);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = 16'h0000;
        done = 1'b0;
        lock = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        req  = 16'hFFFF;
        done = 1'b0;
        lock = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state grant=%h busy=%b want grant=0000 busy=0", grant, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 16'h0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant grant=%h busy=%b want 0001/1", grant, busy);
        end
    endtask

    task automatic test_rotation();
        logic [15:0] exp_g;
        for (int k = 1; k <= 16; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== 16'h0000) begin
                errors++;
                $display("FAIL rot_idle k=%0d grant=%h want 0000", k, grant);
            end
            tick();
            exp_g = 16'h0001 << (k % 16);
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rot_grant k=%0d grant=%h want %h", k, grant, exp_g);
            end
            checks++;
            if (enc(grant) != (k % 16)) begin
                errors++;
                $display("FAIL rot_enc k=%0d index=%0d want %0d", k, enc(grant), k % 16);
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 16'h8001;
        tick();
        checks++;
        if (grant !== 16'h0001) begin
            errors++;
            $display("FAIL fair_first grant=%h want 0001", grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 16'h8000 || enc(grant) != 15) begin
            errors++;
            $display("FAIL fair_second grant=%h want 8000", grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 16'h0001) begin
            errors++;
            $display("FAIL fair_wrap grant=%h want 0001", grant);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        req = 16'h0010;
        tick();
        checks++;
        if (grant !== 16'h0010 || enc(grant) != 4) begin
            errors++;
            $display("FAIL abandon_grant grant=%h want 0010", grant);
        end
        // Non-owner request changes must not disturb the held grant.
        req = 16'h0013;
        tick();
        checks++;
        if (grant !== 16'h0010) begin
            errors++;
            $display("FAIL abandon_hold grant=%h want 0010", grant);
        end
        req = 16'h0000;
        tick();
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abandon_release grant=%h busy=%b want 0000/0", grant, busy);
        end
        req = 16'h0011;
        tick();
        checks++;
        if (grant !== 16'h0001) begin
            errors++;
            $display("FAIL abandon_next grant=%h want 0001", grant);
        end
    endtask

    task automatic test_done_idle();
        do_reset();
        done = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 16'h0000) begin
            errors++;
            $display("FAIL done_idle_grant grant=%h want 0000", grant);
        end
        done = 1'b0;
        req  = 16'h0003;
        tick();
        checks++;
        if (grant !== 16'h0001) begin
            errors++;
            $display("FAIL done_idle_ptr grant=%h want 0001", grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0020;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h0100;
        tick();
        checks++;
        if (grant !== 16'h0100) begin
            errors++;
            $display("FAIL areset_setup grant=%h want 0100", grant);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate grant=%h busy=%b want 0000/0", grant, busy);
        end
        tick();
        rst = 1'b0;
        // Bits 3 and 8: pointer 0 picks bit 3, a stale pointer of 6 would pick bit 8.
        req = 16'h0108;
        tick();
        checks++;
        if (grant !== 16'h0008) begin
            errors++;
            $display("FAIL areset_ptr grant=%h want 0008", grant);
        end
        do_reset();
        req = 16'h0100;
        tick();
        checks++;
        if (grant !== 16'h0100) begin
            errors++;
            $display("FAIL areset_regrant grant=%h want 0100", grant);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 16'h0004;
        tick();
        lock = 1'b1;
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== 16'h0004) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d grant=%h want 0004", i, grant);
            end
        end
        lock = 1'b0;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 16'h0000) begin
            errors++;
            $display("FAIL lock_release grant=%h want 0000", grant);
        end
    endtask
`endif

    initial begin
        rst  = 1'b1;
        req  = 16'h0000;
        done = 1'b0;
        lock = 1'b0;
        test_reset();
        test_rotation();
        test_fairness();
        test_abandon();
        test_done_idle();
        test_async_reset();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
